arith_share_arbiter: RTL

- Round-robin arbiter and sequencer that shares one pipelined arithmetic unit among NUM_REQ requesters.
- The unit performs an add or a multiply and produces a 2*WIDTH-bit result, with the same result convention as the adder/multiplier DUTs.
- Each accepted operation is tagged with its requester id and returns after a fixed LATENCY.
- A requester may have at most one operation outstanding.
- Sits between multiple operand sources and the single adder/multiplier datapath.

---
 rtl/arith_share_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/arith_share_arbiter.sv
// Round-robin arbiter that shares one pipelined add/multiply unit among
// NUM_REQ requesters. Each accepted operation is tagged with its requester
// id and returns after exactly LATENCY cycles, in accept order.
module arith_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]                      req_a,
  input  logic [NUM_REQ*WIDTH-1:0]                      req_b,
  input  logic [NUM_REQ-1:0]                            req_op,
  output logic                                          rsp_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]                            rsp_result,
  output logic [NUM_REQ-1:0]                            pending
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW  = 2 * WIDTH;

  // Add keeps the carry (zero-extended WIDTH+1 bit sum); multiply is the
  // full unsigned 2*WIDTH-bit product.
  function automatic logic [RW-1:0] calc_result(input logic             op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    if (op) return RW'(a) * RW'(b);
    return RW'(a) + RW'(b);
  endfunction

  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] eligible;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     idx;
  logic [WIDTH-1:0]   acc_a;
  logic [WIDTH-1:0]   acc_b;
  logic               acc_op;

  // Signals feeding the response register from the last internal stage.
  logic               last_vld;
  logic [IDW-1:0]     last_id;
  logic [RW-1:0]      last_res;

  assign eligible = req_valid & ~pending;

  // Search eligible requesters starting at ptr, wrapping; first hit is granted.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx = IDW'((int'(ptr) + o) % NUM_REQ);
      if (!gnt_any && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (reset) gnt_any = 1'b0;
    req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
  end

  assign acc_a  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign acc_b  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
  assign acc_op = req_op[gnt_id];

  // Advance the round-robin pointer past the requester just accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Track one outstanding operation per requester: set on accept, clear on
  // the edge where its response is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~(rsp_valid ? (NUM_REQ'(1) << rsp_id) : NUM_REQ'(0)))
                 | req_ready;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      // With a single stage the result is formed straight from the granted
      // operands and lands in the response register.
      assign last_vld = gnt_any;
      assign last_id  = gnt_id;
      assign last_res = calc_result(acc_op, acc_a, acc_b);
    end else begin : g_pipe
      logic             vld_p0;
      logic [IDW-1:0]   id_p0;
      logic             op_p0;
      logic [WIDTH-1:0] a_p0;
      logic [WIDTH-1:0] b_p0;
      logic [RW-1:0]    res_p0;

      // ---- stage 1: accepted operands and tag ----
      // Valid bit is reset so a reset discards everything in flight.
      always_ff @(posedge clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= gnt_any;
      end

      // Operand capture needs no reset; it is qualified by vld_p0.
      always_ff @(posedge clk) begin
        id_p0 <= gnt_id;
        op_p0 <= acc_op;
        a_p0  <= acc_a;
        b_p0  <= acc_b;
      end

      assign res_p0 = calc_result(op_p0, a_p0, b_p0);

      if (LATENCY == 2) begin : g_two
        assign last_vld = vld_p0;
        assign last_id  = id_p0;
        assign last_res = res_p0;
      end else begin : g_deep
        logic           vld_p1 [LATENCY-2];
        logic [IDW-1:0] id_p1  [LATENCY-2];
        logic [RW-1:0]  res_p1 [LATENCY-2];

        // ---- stages 2..LATENCY-1: result delay line ----
        // Shift the valid bits, clearing them on reset.
        always_ff @(posedge clk) begin
          if (reset) begin
            for (int j = 0; j < LATENCY - 2; j++) vld_p1[j] <= 1'b0;
          end else begin
            vld_p1[0] <= vld_p0;
            for (int j = 1; j < LATENCY - 2; j++) vld_p1[j] <= vld_p1[j-1];
          end
        end

        // Shift id and result alongside their valid bits.
        always_ff @(posedge clk) begin
          id_p1[0]  <= id_p0;
          res_p1[0] <= res_p0;
          for (int j = 1; j < LATENCY - 2; j++) begin
            id_p1[j]  <= id_p1[j-1];
            res_p1[j] <= res_p1[j-1];
          end
        end

        assign last_vld = vld_p1[LATENCY-3];
        assign last_id  = id_p1[LATENCY-3];
        assign last_res = res_p1[LATENCY-3];
      end
    end
  endgenerate

  // ---- final stage: response register ----
  // id and result only load with a valid response so they hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      rsp_valid <= last_vld;
      if (last_vld) begin
        rsp_id     <= last_id;
        rsp_result <= last_res;
      end
    end
  end

endmodule
